// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller for the board-level CPU clock path.
// It issues single-cycle pipeline clock-enable pulses from the system clock.
module cpu_clk_ctrl #(
    parameter int DIV   = 100000000,
    parameter int CNT_W = 27
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        run_i,
    input  logic        step_i,
    input  logic        halt_i,
    output logic        cpu_ce_o,
    output logic [1:0]  state_o,
    output logic        halted_o,
    output logic [31:0] ce_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    logic             run_meta_q, run_s_q;
    logic             step_meta_q, step_s_q, step_d_q;
    logic             step_edge;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             ce_q, ce_d;
    logic             halted_q, halted_d;
    logic [31:0]      ce_cnt_q, ce_cnt_d;

    assign step_edge = step_s_q & ~step_d_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ce_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_s_q) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                end else if (step_edge) begin
                    state_d = STEP;
                    ce_d    = 1'b1;
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                // A breakpoint suppresses even a pulse that is due this cycle.
                if (halt_i) begin
                    state_d = HALT;
                end else if (!run_s_q) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DIV_M1) begin
                    div_cnt_d = '0;
                    ce_d      = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HALT: begin
                if (!run_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        halted_d = (state_d == HALT);
        ce_cnt_d = ce_cnt_q + {31'b0, ce_d};
    end

    // NOTE: asynchronous reset clears every flop, so a pending pulse dies the moment rst falls.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            run_meta_q  <= 1'b0;
            run_s_q     <= 1'b0;
            step_meta_q <= 1'b0;
            step_s_q    <= 1'b0;
            step_d_q    <= 1'b0;
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            ce_q        <= 1'b0;
            halted_q    <= 1'b0;
            ce_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, keeping the sync chain intact.
            run_meta_q  <= run_i;
            run_s_q     <= run_meta_q;
            step_meta_q <= step_i;
            step_s_q    <= step_meta_q;
            step_d_q    <= step_s_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            ce_q        <= ce_d;
            halted_q    <= halted_d;
            ce_cnt_q    <= ce_cnt_d;
        end
    end

    assign cpu_ce_o = ce_q;
    assign state_o  = state_q;
    assign halted_o = halted_q;
    assign ce_cnt_o = ce_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: expected pulses are queued with their due
// cycle and ce count, and a negedge monitor pops and compares each pulse.
module tb_cpu_clk_ctrl;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b0;
    logic        run_i = 1'b1, step_i = 1'b0, halt_i = 1'b0;
    logic        run1 = 1'b0, step1 = 1'b0, halt1 = 1'b0;
    logic        ce4, ce1, halted4, halted1;
    logic [1:0]  state4, state1;
    logic [31:0] cnt4, cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int cyc; int cnt; } pulse_t;
    pulse_t exp_q[$];

    cpu_clk_ctrl #(.DIV(4), .CNT_W(3)) dut4 (
        .clk_i(clk_i), .rst(rst), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .cpu_ce_o(ce4), .state_o(state4), .halted_o(halted4), .ce_cnt_o(cnt4)
    );

    cpu_clk_ctrl #(.DIV(1), .CNT_W(1)) dut1 (
        .clk_i(clk_i), .rst(rst), .run_i(run1), .step_i(step1), .halt_i(halt1),
        .cpu_ce_o(ce1), .state_o(state1), .halted_o(halted1), .ce_cnt_o(cnt1)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic void push(input int c, input int n);
        pulse_t p;
        p.cyc = c;
        p.cnt = n;
        exp_q.push_back(p);
    endfunction

    always @(negedge clk_i) begin
        if (ce4 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pulse_queued", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                pulse_t p;
                p = exp_q.pop_front();
                check("pulse_cyc", 32'(cyc), 32'(p.cyc));
                check("pulse_cnt", cnt4, 32'(p.cnt));
            end
        end
    end

    initial begin
        int c0;

        // Reset held with run switch up
        tick(3);
        check("rst_state", 32'(state4), 0);
        check("rst_ce", 32'(ce4), 0);
        check("rst_halted", 32'(halted4), 0);
        check("rst_cnt", cnt4, 0);

        // Release reset: RUN three edges later, pulses every 4 cycles
        c0 = cyc;
        rst = 1'b1;
        push(c0 + 7, 1); push(c0 + 11, 2); push(c0 + 15, 3);
        tick(2);
        check("t1_state_idle", 32'(state4), 0);
        tick(1);
        check("t1_state_run", 32'(state4), 1);
        tick(12);
        check("t1_cnt", cnt4, 3);
        #1 check("t1_drained", 32'(exp_q.size()), 0);

        // Drop run mid-count, then re-enter RUN: count restarts from zero
        @(negedge clk_i);
        run_i = 1'b0;
        tick(2);
        check("t4_state_run", 32'(state4), 1);
        tick(1);
        check("t4_state_idle", 32'(state4), 0);
        tick(10);
        c0 = cyc;
        run_i = 1'b1;
        push(c0 + 7, 4);
        tick(3);
        check("t4_rerun", 32'(state4), 1);

        // Breakpoint in the cycle where count = DIV-1
        tick(7);
        halt_i = 1'b1;
        tick(1);
        halt_i = 1'b0;
        check("t3_state_halt", 32'(state4), 3);
        check("t3_halted", 32'(halted4), 1);
        check("t3_cnt", cnt4, 4);
        #1 check("t3_drained", 32'(exp_q.size()), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); step_i = 1'b1;
            tick(4);          step_i = 1'b0;
            tick(3);
        end
        halt_i = 1'b1; tick(1); halt_i = 1'b0; tick(3);
        check("t3_still_halt", 32'(state4), 3);
        check("t3_cnt_held", cnt4, 4);
        run_i = 1'b0;
        tick(2);
        check("t3_halt_sync", 32'(state4), 3);
        tick(1);
        check("t3_exit_idle", 32'(state4), 0);
        check("t3_halted_clr", 32'(halted4), 0);

        // Step button held 50 cycles: one pulse only
        tick(2);
        c0 = cyc;
        step_i = 1'b1;
        push(c0 + 3, 5);
        tick(3);
        check("t2_state_step", 32'(state4), 2);
        tick(1);
        check("t2_state_idle", 32'(state4), 0);
        tick(46);
        step_i = 1'b0;
        tick(4);
        check("t2_cnt", cnt4, 5);
        #1 check("t2_drained", 32'(exp_q.size()), 0);

        // DIV = 1 pulses every cycle; DIV = 4 unit arrives at a due pulse
        @(negedge clk_i);
        run1 = 1'b1;
        tick(3);
        check("t5_state", 32'(state1), 1);
        check("t5_ce_first", 32'(ce1), 0);
        run_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("t5_ce", 32'(ce1), 1);
            check("t5_cnt", cnt1, 32'(k));
        end
        check("t6_pre_state", 32'(state4), 1);
        check("t6_pre_cnt", cnt4, 5);

        // Asynchronous reset mid-cycle, with a pulse due at the next edge
        #2 rst = 1'b0;
        #1;
        check("t6_ce1", 32'(ce1), 0);
        check("t6_cnt1", cnt1, 0);
        check("t6_state1", 32'(state1), 0);
        check("t6_ce4", 32'(ce4), 0);
        check("t6_cnt4", cnt4, 0);
        check("t6_state4", 32'(state4), 0);
        check("t6_halted4", 32'(halted4), 0);
        tick(3);
        check("t6_ce1_held", 32'(ce1), 0);
        check("t6_cnt4_held", cnt4, 0);
        #1 check("t6_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
